// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM access arbiter.
// State encoding and requester port ids.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester handshakes and SRAM pins of the arbiter.
// slave = arbiter side, master = requesters plus SRAM data return.
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  logic              Req0;
  logic              Req1;
  logic              We0;
  logic              We1;
  logic [ADDR_W-1:0] Addr0;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] WData0;
  logic [DATA_W-1:0] WData1;
  logic              Ack0;
  logic              Ack1;
  logic [DATA_W-1:0] RData;
  logic              Mem_CE;
  logic              Mem_OE;
  logic              Mem_WE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic [ADDR_W-1:0] Mem_ADDR;
  logic [DATA_W-1:0] Mem_DOut;
  logic              Mem_DOE;
  logic [DATA_W-1:0] Mem_DIn;

  modport slave (
    input  Req0, Req1, We0, We1,
    input  Addr0, Addr1, WData0, WData1,
    input  Mem_DIn,
    output Ack0, Ack1, RData,
    output Mem_CE, Mem_OE, Mem_WE,
    output Mem_UB, Mem_LB,
    output Mem_ADDR, Mem_DOut, Mem_DOE
  );

  modport master (
    output Req0, Req1, We0, We1,
    output Addr0, Addr1, WData0, WData1,
    output Mem_DIn,
    input  Ack0, Ack1, RData,
    input  Mem_CE, Mem_OE, Mem_WE,
    input  Mem_UB, Mem_LB,
    input  Mem_ADDR, Mem_DOut, Mem_DOE
  );

endinterface

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one async SRAM between CPU and DMA.
// Each access holds the strobes for WAIT_CYCLES, then pulses Ack.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 3
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sram_access_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick;

  // Contention goes to the port that did not win last time.
  always_comb begin
    pick = PORT_CPU;
    unique case (1'b1)
      (bus.Req0 && bus.Req1): pick = ~last_q;
      (bus.Req1 && !bus.Req0): pick = PORT_DMA;
      default: pick = PORT_CPU;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          state_d = ARB_ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          last_d  = pick;
          wr_d    = pick ? bus.We1 : bus.We0;
          addr_d  = pick ? bus.Addr1 : bus.Addr0;
          dout_d  = pick ? bus.WData1 : bus.WData0;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ARB_DONE;
          if (!wr_q) rdata_d = bus.Mem_DIn;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      last_q  <= PORT_DMA;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

  logic in_acc;
  logic in_done;

  // Strobes decode from registered state only, so they cannot glitch.
  assign in_acc  = (state_q == ARB_ACCESS);
  assign in_done = (state_q == ARB_DONE);

  assign bus.Mem_CE   = ~in_acc;
  assign bus.Mem_UB   = ~in_acc;
  assign bus.Mem_LB   = ~in_acc;
  assign bus.Mem_OE   = ~(in_acc && !wr_q);
  assign bus.Mem_WE   = ~(in_acc && wr_q);
  assign bus.Mem_DOE  = in_acc && wr_q;
  assign bus.Mem_ADDR = addr_q;
  assign bus.Mem_DOut = dout_q;
  assign bus.RData    = rdata_q;
  assign bus.Ack0     = in_done && (last_q == PORT_CPU);
  assign bus.Ack1     = in_done && (last_q == PORT_DMA);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: directed table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_sram_access_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int W3 = 3;

  typedef struct {
    logic        port;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();
  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  sram_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W3)
  ) u3 (
    .Clk(clk), .Reset_n(rst_n), .bus(b3)
  );

  sram_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)
  ) u1 (
    .Clk(clk), .Reset_n(rst_n), .bus(b1)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] init_val(int a);
    return 16'(a * 37) ^ 16'h5A00;
  endfunction

  // Async SRAM models, 1K words indexed by the low address bits
  logic [15:0] sram3 [0:1023];
  logic [15:0] sram1 [0:1023];
  bit inited = 1'b0;

  always @(negedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 1024; i++) begin
        sram3[i] = init_val(i);
        sram1[i] = init_val(i);
      end
      sram3[16] = 16'hBEEF;
      sram1[32] = 16'hC0DE;
      inited = 1'b1;
    end else begin
      if (!b3.Mem_CE && !b3.Mem_WE)
        sram3[b3.Mem_ADDR[9:0]] = b3.Mem_DOut;
      if (!b1.Mem_CE && !b1.Mem_WE)
        sram1[b1.Mem_ADDR[9:0]] = b1.Mem_DOut;
    end
  end

  assign b3.Mem_DIn = (!b3.Mem_CE && !b3.Mem_OE) ?
                      sram3[b3.Mem_ADDR[9:0]] : 16'h0000;
  assign b1.Mem_DIn = (!b1.Mem_CE && !b1.Mem_OE) ?
                      sram1[b1.Mem_ADDR[9:0]] : 16'h0000;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive3(logic p, logic r, logic w,
                        logic [19:0] a, logic [15:0] d);
    if (p == 1'b0) begin
      b3.Req0 = r; b3.We0 = w; b3.Addr0 = a; b3.WData0 = d;
    end else begin
      b3.Req1 = r; b3.We1 = w; b3.Addr1 = a; b3.WData1 = d;
    end
  endtask

  task automatic do_access(input vec_t v,
                           output int ack_at, output int oe_n,
                           output int we_n, output int doe_n,
                           output int ce_n, output int ack_n,
                           output int oth_n,
                           output logic [19:0] a_seen,
                           output logic [15:0] rd_ack);
    ack_at = -1; oe_n = 0; we_n = 0; doe_n = 0; ce_n = 0;
    ack_n = 0; oth_n = 0; a_seen = '0; rd_ack = '0;
    drive3(v.port, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) a_seen = b3.Mem_ADDR;
      oe_n  += int'(!b3.Mem_OE);
      we_n  += int'(!b3.Mem_WE);
      ce_n  += int'(!b3.Mem_CE);
      doe_n += int'(b3.Mem_DOE);
      if (v.port ? b3.Ack1 : b3.Ack0) begin
        ack_n++;
        if (ack_at < 0) begin
          ack_at = k;
          rd_ack = b3.RData;
        end
        drive3(v.port, 1'b0, v.we, v.addr, v.wdata);
      end
      if (v.port ? b3.Ack0 : b3.Ack1) oth_n++;
    end
  endtask

  initial begin
    vec_t tbl [5];
    int ack_at, oe_n, we_n, doe_n, ce_n, ack_n, oth_n;
    logic [19:0] a_seen;
    logic [15:0] rd_ack;
    logic [15:0] prev_rd;
    logic mlast, mport, mread;
    bit busy, p0, p1;
    int ack_edge, nf;
    logic [15:0] mexp;
    logic w0, w1;
    logic [19:0] a0, a1, ga;
    logic [15:0] d0, d1;
    logic [15:0] refmem [int];

    tbl[0] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b1, 1'b1, 20'h0FFFF, 16'h1234, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 20'h00100, 16'hA5A5, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 20'h00100, 16'h0000, 16'hA5A5};
    tbl[4] = '{1'b1, 1'b0, 20'h0FFFF, 16'h0000, 16'h1234};

    drive3(1'b0, 1'b0, 1'b0, '0, '0);
    drive3(1'b1, 1'b0, 1'b0, '0, '0);
    b1.Req0 = 0; b1.We0 = 0; b1.Addr0 = '0; b1.WData0 = '0;
    b1.Req1 = 0; b1.We1 = 0; b1.Addr1 = '0; b1.WData1 = '0;

    #3;
    chk("rst_strobes", {b3.Mem_CE, b3.Mem_OE, b3.Mem_WE,
                        b3.Mem_UB, b3.Mem_LB}, 5'b11111);
    chk("rst_doe", b3.Mem_DOE, 1'b0);
    chk("rst_acks", {b3.Ack0, b3.Ack1}, 2'b00);
    chk("rst_rdata", b3.RData, 16'h0);
    chk("rst_addr", b3.Mem_ADDR, 20'h0);
    chk("rst_dout", b3.Mem_DOut, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of a write
    drive3(1'b1, 1'b1, 1'b1, 20'h003F0, 16'hDEAD);
    repeat (2) @(negedge clk);
    chk("prerst_we", b3.Mem_WE, 1'b0);
    chk("prerst_doe", b3.Mem_DOE, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {b3.Mem_CE, b3.Mem_OE, b3.Mem_WE,
                         b3.Mem_UB, b3.Mem_LB}, 5'b11111);
    chk("arst_doe", b3.Mem_DOE, 1'b0);
    chk("arst_acks", {b3.Ack0, b3.Ack1}, 2'b00);
    drive3(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports held: grants 0,1,0,1 every 5 cycles
    drive3(1'b0, 1'b1, 1'b0, 20'h00010, 16'h0);
    drive3(1'b1, 1'b1, 1'b0, 20'h00020, 16'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("cont_ack0", b3.Ack0, (k == 4 || k == 14));
      chk("cont_ack1", b3.Ack1, (k == 9 || k == 19));
      if (k == 4) chk("cont_rd0", b3.RData, 16'hBEEF);
      if (k == 9) chk("cont_rd1", b3.RData, init_val(32));
      if (k == 19) begin
        drive3(1'b0, 1'b0, 1'b0, '0, '0);
        drive3(1'b1, 1'b0, 1'b0, '0, '0);
      end
    end
    repeat (2) @(negedge clk);
    prev_rd = init_val(32);

    for (int i = 0; i < 5; i++) begin
      do_access(tbl[i], ack_at, oe_n, we_n, doe_n, ce_n,
                ack_n, oth_n, a_seen, rd_ack);
      chk($sformatf("t%0d_lat", i), ack_at, W3 + 1);
      chk($sformatf("t%0d_acks", i), ack_n, 1);
      chk($sformatf("t%0d_other", i), oth_n, 0);
      chk($sformatf("t%0d_ce", i), ce_n, W3);
      chk($sformatf("t%0d_oe", i), oe_n, tbl[i].we ? 0 : W3);
      chk($sformatf("t%0d_we", i), we_n, tbl[i].we ? W3 : 0);
      chk($sformatf("t%0d_doe", i), doe_n, tbl[i].we ? W3 : 0);
      chk($sformatf("t%0d_addr", i), a_seen, tbl[i].addr);
      if (tbl[i].we) begin
        chk($sformatf("t%0d_mem", i),
            sram3[tbl[i].addr[9:0]], tbl[i].wdata);
        chk($sformatf("t%0d_rhold", i), b3.RData, prev_rd);
        chk($sformatf("t%0d_dout", i), b3.Mem_DOut, tbl[i].wdata);
      end else begin
        chk($sformatf("t%0d_rd", i), rd_ack, tbl[i].exp_rd);
        chk($sformatf("t%0d_rhold", i), b3.RData, tbl[i].exp_rd);
        prev_rd = tbl[i].exp_rd;
      end
    end

    // One-wait-state build; inputs moved mid-access are ignored
    b1.Req0 = 1'b1; b1.We0 = 1'b0; b1.Addr0 = 20'h00020;
    @(negedge clk);
    chk("w1_addr1", b1.Mem_ADDR, 20'h00020);
    chk("w1_oe", b1.Mem_OE, 1'b0);
    chk("w1_noack", b1.Ack0, 1'b0);
    b1.Addr0 = 20'h00055; b1.We0 = 1'b1;
    @(negedge clk);
    chk("w1_ack", b1.Ack0, 1'b1);
    chk("w1_ack1", b1.Ack1, 1'b0);
    chk("w1_rd", b1.RData, 16'hC0DE);
    chk("w1_addr2", b1.Mem_ADDR, 20'h00020);
    chk("w1_we", b1.Mem_WE, 1'b1);
    b1.Req0 = 1'b0;
    @(negedge clk);
    chk("w1_ackoff", b1.Ack0, 1'b0);
    chk("w1_addr3", b1.Mem_ADDR, 20'h00020);

    // Random traffic vs. transaction-level model
    mlast = tbl[4].port;
    busy = 0; p0 = 0; p1 = 0; nf = 0; ack_edge = 0;
    mport = 0; mread = 0; mexp = '0;
    w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int m = 1; m <= 600; m++) begin
      @(negedge clk);
      chk("rnd_ack0", b3.Ack0,
          busy && m == ack_edge && mport == 1'b0);
      chk("rnd_ack1", b3.Ack1,
          busy && m == ack_edge && mport == 1'b1);
      if (busy && m == ack_edge) begin
        if (mread) chk("rnd_rdata", b3.RData, mexp);
        busy = 0;
      end
      if (b3.Ack0) begin p0 = 0; b3.Req0 = 1'b0; end
      if (b3.Ack1) begin p1 = 0; b3.Req1 = 1'b0; end
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1;
        w0 = 1'($urandom_range(0, 1));
        a0 = 20'h00200 + 20'($urandom_range(0, 31));
        d0 = 16'($urandom);
        drive3(1'b0, 1'b1, w0, a0, d0);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1;
        w1 = 1'($urandom_range(0, 1));
        a1 = 20'h00200 + 20'($urandom_range(0, 31));
        d1 = 16'($urandom);
        drive3(1'b1, 1'b1, w1, a1, d1);
      end
      if (!busy && m + 1 >= nf && (p0 || p1)) begin
        mport = (p0 && p1) ? ~mlast : p1;
        mlast = mport;
        busy = 1;
        ack_edge = m + 1 + W3;
        nf = m + 1 + W3 + 2;
        mread = mport ? !w1 : !w0;
        ga = mport ? a1 : a0;
        if (mread)
          mexp = refmem.exists(int'(ga)) ?
                 refmem[int'(ga)] : init_val(int'(ga));
        else
          refmem[int'(ga)] = mport ? d1 : d0;
      end
    end
    drive3(1'b0, 1'b0, 1'b0, '0, '0);
    drive3(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
